// File: rtl/jesd_ctrl_pkg.sv
// Shared JESD link-control definitions: FSM state encoding and timing defaults.
package jesd_ctrl_pkg;

    typedef enum logic [1:0] {
        SYNC_REQ   = 2'd0,
        WAIT_BND   = 2'd1,
        LINK_UP    = 2'd2,
        ERR_REPORT = 2'd3
    } sync_state_t;

    localparam int unsigned REQ_MIN_DEF = 5;
    localparam int unsigned ERR_LEN_DEF = 2;

endpackage

// File: rtl/lmfc_frame_counter.sv
// Frame index within the multiframe plus multiframe-boundary strobe.
module lmfc_frame_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_clk,
    input  logic [4:0] i_K,
    output logic [4:0] o_frame_no,
    output logic       o_mf_bnd
);

    // >= rather than == so a K lowered below the current index still wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_frame_no <= '0;
        end else if (frame_clk) begin
            if (o_frame_no >= i_K) o_frame_no <= '0;
            else                   o_frame_no <= o_frame_no + 5'd1;
        end
    end

    always_comb begin
        o_mf_bnd = frame_clk && (o_frame_no == i_K);
    end

endmodule

// File: rtl/syncn_generator.sv
// Receiver-side SYNC~ driver: sync request, aligned release and error reporting.
module syncn_generator
    import jesd_ctrl_pkg::*;
#(
    parameter int unsigned LANES   = 1,
    parameter int unsigned REQ_MIN = REQ_MIN_DEF,
    parameter int unsigned ERR_LEN = ERR_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_clk,
    input  logic [4:0]       i_K,
    input  logic             i_lmfc_align,
    input  logic [LANES-1:0] i_lane_cgs_done,
    input  logic             i_resync_req,
    input  logic             i_err,
    input  logic             i_err_report_en,
    output logic             o_sync_n,
    output logic             o_link_up,
    output logic [4:0]       o_frame_no,
    output logic [7:0]       o_err_cnt
);

    sync_state_t state, state_nxt;
    logic [2:0]  req_cnt;
    logic [1:0]  err_frm;
    logic        gap_ok;
    logic        pending;
    logic        mf_bnd;
    logic        cgs_all;
    logic        abort;
    logic        err_req;
    logic        qual;
    logic        sync_n_nxt;

    lmfc_frame_counter u_frame_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_clk  (frame_clk),
        .i_K        (i_K),
        .o_frame_no (o_frame_no),
        .o_mf_bnd   (mf_bnd)
    );

    always_comb begin
        cgs_all = &i_lane_cgs_done;
        abort   = (state != SYNC_REQ) && (!cgs_all || i_resync_req);
        err_req = i_err && i_err_report_en;
        qual    = i_lmfc_align ? mf_bnd : frame_clk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC_REQ;
        else        state <= state_nxt;
    end

    // A strobe while high completes the guard frame, so a queued report may go out on it
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = SYNC_REQ;
        end else begin
            unique case (state)
                SYNC_REQ:   if (!i_resync_req && req_cnt == 3'(REQ_MIN) && cgs_all)
                                state_nxt = WAIT_BND;
                WAIT_BND:   if (qual) state_nxt = LINK_UP;
                LINK_UP:    if ((err_req || pending) && (gap_ok || frame_clk))
                                state_nxt = ERR_REPORT;
                ERR_REPORT: if (frame_clk && err_frm == 2'(ERR_LEN - 1))
                                state_nxt = LINK_UP;
                default:    state_nxt = SYNC_REQ;
            endcase
        end
    end

    always_comb begin
        sync_n_nxt = (state_nxt == LINK_UP);
        o_link_up  = (state == LINK_UP) || (state == ERR_REPORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_sync_n <= 1'b0;
        else        o_sync_n <= sync_n_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt <= '0;
        end else if (state != SYNC_REQ) begin
            if (state_nxt == SYNC_REQ) req_cnt <= '0;
        end else if (i_resync_req) begin
            req_cnt <= '0;
        end else if (frame_clk && req_cnt != 3'(REQ_MIN)) begin
            req_cnt <= req_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_frm <= '0;
        end else if (state_nxt == ERR_REPORT && state != ERR_REPORT) begin
            err_frm <= '0;
        end else if (state == ERR_REPORT && frame_clk) begin
            err_frm <= err_frm + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_ok <= 1'b0;
        end else if (state_nxt == ERR_REPORT && state != ERR_REPORT) begin
            gap_ok <= 1'b0;
        end else if (state == SYNC_REQ || state == WAIT_BND) begin
            gap_ok <= 1'b1;
        end else if (state == LINK_UP && frame_clk) begin
            gap_ok <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (abort) begin
            pending <= 1'b0;
        end else if (state == LINK_UP) begin
            if (state_nxt == ERR_REPORT) pending <= 1'b0;
            else if (err_req)            pending <= 1'b1;
        end else if (state == ERR_REPORT && err_req) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err_cnt <= '0;
        end else if (o_link_up && i_err && o_err_cnt != 8'hFF) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_syncn_generator.sv
// Directed bench for syncn_generator: sync request, release alignment, error reports.
module tb_syncn_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [4:0] K = 5'd3;
    logic       lmfc_align = 1'b0;
    logic [1:0] cgs = 2'b00;
    logic       resync = 1'b0;
    logic       err = 1'b0;
    logic       err_en = 1'b1;
    logic       sync_n;
    logic       link_up;
    logic [4:0] frame_no;
    logic [7:0] err_cnt;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    logic [4:0]  fno = 5'd0;

    syncn_generator #(.LANES(2), .REQ_MIN(5), .ERR_LEN(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_clk       (frame_clk),
        .i_K             (K),
        .i_lmfc_align    (lmfc_align),
        .i_lane_cgs_done (cgs),
        .i_resync_req    (resync),
        .i_err           (err),
        .i_err_report_en (err_en),
        .o_sync_n        (sync_n),
        .o_link_up       (link_up),
        .o_frame_no      (frame_no),
        .o_err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; frame_clk alternates so a strobe lands every other edge
    task automatic step();
        logic fc;
        fc = frame_clk;
        @(posedge clk);
        #1;
        if (!rst_n)  fno = 5'd0;
        else if (fc) fno = (fno >= K) ? 5'd0 : fno + 5'd1;
        frame_clk = ~frame_clk;
    endtask

    task automatic align_strobe();
        if (!frame_clk) step();
    endtask

    task automatic wait_high(input int budget, output int strobes, output logic edge_fc);
        logic fc;
        strobes = 0;
        edge_fc = 1'b0;
        for (int i = 0; i < budget; i++) begin
            fc = frame_clk;
            step();
            if (sync_n) begin
                edge_fc = fc;
                return;
            end
            if (fc) strobes++;
        end
        strobes = 99;
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (!sync_n) lows++;
        end
    endtask

    initial begin
        int          n0;
        int          n1;
        int          lows;
        logic        efc;
        logic [15:0] hist;

        // reset
        step();
        step();
        check("rst_sync_n", sync_n, 0);
        check("rst_link_up", link_up, 0);
        check("rst_frame_no", frame_no, 0);
        check("rst_err_cnt", err_cnt, 0);

        // sync request then release on any frame boundary
        rst_n = 1'b1;
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            if (frame_clk) n0++;
            step();
        end
        cgs = 2'b11;
        wait_high(60, n1, efc);
        check("req_low_strobes", n0 + n1, 5);
        check("rise_after_strobe", efc, 1);
        check("link_up_1", link_up, 1);
        check("frame_no_1", frame_no, fno);

        // re-request with multiframe alignment
        lmfc_align = 1'b1;
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_drop", link_up, 0);
        wait_high(80, n1, efc);
        check("align_req_min", (n1 >= 5) ? 1 : 0, 1);
        check("align_rise_strobe", efc, 1);
        check("align_frame_no", frame_no, 0);
        check("align_link_up", link_up, 1);
        lmfc_align = 1'b0;

        // single error report
        align_strobe();
        err = 1'b1;
        step();
        err = 1'b0;
        check("err_fall", sync_n, 0);
        lows = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sync_n) break;
            lows++;
        end
        check("err_low_clks", lows, 4);
        check("err_cnt_1", err_cnt, 1);
        count_low(6, lows);
        check("err_idle_high", lows, 0);

        // two errors one clock apart: two reports with one frame high between
        align_strobe();
        err = 1'b1;
        step();
        hist[0] = sync_n;
        step();
        hist[1] = sync_n;
        err = 1'b0;
        for (int k = 2; k < 16; k++) begin
            step();
            hist[k] = sync_n;
        end
        check("double_err_pattern", hist, 16'hFC30);
        check("err_cnt_3", err_cnt, 3);

        // lane loss during a report with a pending error queued
        align_strobe();
        err = 1'b1;
        step();
        step();
        err = 1'b0;
        cgs = 2'b10;
        step();
        check("lane_loss_link", link_up, 0);
        check("lane_loss_sync", sync_n, 0);
        cgs = 2'b11;
        wait_high(60, n1, efc);
        check("lane_loss_req", n1, 5);
        check("lane_loss_rise", efc, 1);
        count_low(10, lows);
        check("pending_cleared", lows, 0);
        check("err_cnt_5", err_cnt, 5);

        // error coincident with resync: counted, never reported
        err = 1'b1;
        resync = 1'b1;
        step();
        err = 1'b0;
        resync = 1'b0;
        check("err_resync_link", link_up, 0);
        check("err_resync_cnt", err_cnt, 6);
        wait_high(80, n1, efc);
        check("err_resync_req", (n1 >= 5) ? 1 : 0, 1);
        count_low(10, lows);
        check("err_resync_noreport", lows, 0);

        // saturation with reporting disabled
        err_en = 1'b0;
        err = 1'b1;
        count_low(300, lows);
        err = 1'b0;
        check("sat_no_report", lows, 0);
        check("err_cnt_sat", err_cnt, 255);
        step();
        check("err_cnt_hold", err_cnt, 255);

        // K lowered mid-operation
        K = 5'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("k_change_frame_no", frame_no, fno);
        end
        check("k_change_range", (frame_no <= 5'd1) ? 1 : 0, 1);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sync_n", sync_n, 0);
        check("async_link_up", link_up, 0);
        check("async_err_cnt", err_cnt, 0);
        check("async_frame_no", frame_no, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
